// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: redirect prioritisation, memory-wait holding and IF/ID flush.
// Optional performance counters are enabled with `define PC_SEQ_PERF_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          GAP        = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        pending
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t      state;
  logic [31:0] pend_target;
  logic        redir;
  logic [31:0] target;
  logic        apply;

  assign redir    = exc | jump | branch_taken;
  assign pc_plus4 = pc + 32'(GAP);

  always_comb begin
    target = branch_target;
    if (exc)       target = EXC_VECTOR;
    else if (jump) target = jump_target;
    target[1:0] = 2'b00;
  end

  assign fetch_valid = !rst && (state == RUN) && imem_ready && !stall && !redir;

  // A redirect lands in pc this cycle: taken directly in RUN, or released from PEND.
  assign apply = imem_ready && ((state == RUN && redir) || state == PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_ADDR;
      pend_target <= 32'h0;
      flush       <= 1'b0;
      pending     <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redir && imem_ready) begin
            pc    <= target;
            flush <= 1'b1;
          end else if (redir) begin
            pend_target <= target;
            pending     <= 1'b1;
            state       <= PEND;
          end else if (imem_ready && !stall) begin
            pc <= pc_plus4;
          end
        end
        PEND: begin
          // Younger branch/jump requests are wrong-path here; only an exception overrides.
          if (exc) pend_target <= {EXC_VECTOR[31:2], 2'b00};
          if (imem_ready) begin
            pc      <= exc ? {EXC_VECTOR[31:2], 2'b00} : pend_target;
            flush   <= 1'b1;
            pending <= 1'b0;
            state   <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= 32'h0;
      redirect_count <= 32'h0;
    end else begin
      if (state == RUN && stall && !redir && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'h1;
      if (apply && redirect_count != 32'hFFFF_FFFF)
        redirect_count <= redirect_count + 32'h1;
    end
  end
`else
  logic unused_apply;
  assign unused_apply = apply;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, stall, redirects, PEND holding, wrap and reset.
`timescale 1ns/1ps
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, jump, exc, imem_ready;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, flush, pending;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] stall_cycles, redirect_count;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exc(exc),
    .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .flush(flush), .pending(pending)
`ifdef PC_SEQ_PERF_EN
    , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 0; branch_taken = 0; jump = 0; exc = 0; imem_ready = 1;
    branch_target = 0; jump_target = 0;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_pending", {31'b0, pending}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_fv", {31'b0, fetch_valid}, 0);
    rst = 1'b0;
    #1;
    // 1: BOOT then sequential
    chk("boot_pc", pc, 32'h0);
    chk("boot_fv", {31'b0, fetch_valid}, 0);
    tick();
    chk("run_pc0", pc, 32'h0);
    chk("run_fv", {31'b0, fetch_valid}, 1);
    chk("pc_plus4", pc_plus4, 32'h4);
    tick(); chk("seq4", pc, 32'h4);
    tick(); chk("seq8", pc, 32'h8);
    tick(); chk("seqC", pc, 32'hC);
    tick(); chk("seq10", pc, 32'h10);
    // 2: stall
    stall = 1; #1;
    chk("stall_fv", {31'b0, fetch_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_hold", pc, 32'h10);
    end
    stall = 0;
    tick(); chk("unstall", pc, 32'h14);
    tick(); tick(); tick(); chk("seq20", pc, 32'h20);
    // 3: branch beats stall, target aligned
    branch_taken = 1; branch_target = 32'h203; stall = 1; #1;
    chk("br_fv", {31'b0, fetch_valid}, 0);
    tick();
    chk("br_pc", pc, 32'h200);
    chk("br_flush", {31'b0, flush}, 1);
    branch_taken = 0; stall = 0;
    tick();
    chk("br_next", pc, 32'h204);
    chk("br_flush_end", {31'b0, flush}, 0);
    // 4: jump while memory busy
    imem_ready = 0; jump = 1; jump_target = 32'h400;
    tick();
    chk("jp_hold", pc, 32'h204);
    chk("jp_pend", {31'b0, pending}, 1);
    jump = 0;
    tick();
    chk("jp_hold2", pc, 32'h204);
    chk("jp_pend2", {31'b0, pending}, 1);
    imem_ready = 1; #1;
    chk("pend_fv", {31'b0, fetch_valid}, 0);
    tick();
    chk("jp_pc", pc, 32'h400);
    chk("jp_flush", {31'b0, flush}, 1);
    chk("jp_pend_clr", {31'b0, pending}, 0);
    tick();
    chk("jp_next", pc, 32'h404);
    chk("jp_flush_end", {31'b0, flush}, 0);
    // 5: exception overrides pending jump, branch ignored in PEND
    imem_ready = 0; jump = 1; jump_target = 32'h400;
    tick(); jump = 0;
    exc = 1; tick(); exc = 0;
    branch_taken = 1; branch_target = 32'h300; tick(); branch_taken = 0;
    chk("exc_hold", pc, 32'h404);
    imem_ready = 1;
    tick();
    chk("exc_pc", pc, 32'h80);
    chk("exc_flush", {31'b0, flush}, 1);
    // priority jump over branch, then back-to-back flush
    jump = 1; jump_target = 32'h500; branch_taken = 1; branch_target = 32'h600;
    tick();
    chk("prio_pc", pc, 32'h500);
    jump = 0;
    tick();
    chk("b2b_pc", pc, 32'h600);
    chk("b2b_flush", {31'b0, flush}, 1);
    branch_taken = 0;
    // 6: wrap-around
    jump = 1; jump_target = 32'hFFFF_FFF8;
    tick(); jump = 0;
    chk("wrap_start", pc, 32'hFFFF_FFF8);
    tick(); chk("wrap_fc", pc, 32'hFFFF_FFFC);
    tick(); chk("wrap_0", pc, 32'h0);
`ifdef PC_SEQ_PERF_EN
    chk("perf_stall", stall_cycles, 32'd3);
    chk("perf_redir", redirect_count, 32'd6);
`endif
    // reset in PEND takes effect immediately
    imem_ready = 0; jump = 1; jump_target = 32'h700;
    tick(); jump = 0;
    chk("pend_pre_rst", {31'b0, pending}, 1);
    rst = 1; #1;
    chk("async_pc", pc, 32'h0);
    chk("async_pending", {31'b0, pending}, 0);
    chk("async_fv", {31'b0, fetch_valid}, 0);
`ifdef PC_SEQ_PERF_EN
    chk("async_stallc", stall_cycles, 32'h0);
    chk("async_redirc", redirect_count, 32'h0);
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter register for the fetch stage and sequences its next value.
- Sources, in priority order: exception vector, jump target, branch target, hold (stall or memory wait), sequential PC+GAP.
- Handshakes with instruction memory. Holds redirects that arrive while memory is busy.
- Issues a one-cycle flush to the IF/ID stage after every applied redirect.
- Sits between the hazard unit, the EX-stage branch resolver and the instruction memory port.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
GAP, 4, sequential increment in bytes (32-bit instruction / 8).
EXC_VECTOR, 32'h0000_0080, exception entry address.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
stall  input  1  hazard unit freeze of PC and IF/ID.
branch_taken  input  1  EX-stage resolved taken branch, 1-cycle pulse.
branch_target  input  32  branch destination.
jump  input  1  ID-stage jump, 1-cycle pulse.
jump_target  input  32  jump destination.
exc  input  1  exception request, 1-cycle pulse.
imem_ready  input  1  instruction memory returns the word at pc this cycle.
pc  output  32  current fetch address (registered).
pc_plus4  output  32  pc + GAP, combinational, wraps mod 2^32.
fetch_valid  output  1  the word at pc is accepted into IF/ID this cycle.
flush  output  1  registered, kill IF/ID contents.
pending  output  1  a redirect is latched and awaiting imem_ready.

Behaviour:
- Reset (asynchronous, any state, including mid-wait or with a redirect pending):
  - pc=RESET_ADDR, state=BOOT, flush=0, pending=0, pend_target=0.
  - fetch_valid is low during reset.
- States:
  - BOOT: one cycle, no fetch; goes to RUN.
  - RUN: normal fetch.
  - PEND: redirect latched; waiting for memory.
- Redirect request: redir = exc | jump | branch_taken.
  - Target priority: exc -> EXC_VECTOR; else jump -> jump_target; else branch_target.
  - Targets have bits [1:0] forced to 0.
- RUN, per cycle:
  - redir & imem_ready: pc<=target; flush=1 next cycle. Applies even if stall=1; redirect beats stall.
  - redir & !imem_ready: pend_target<=target; pending<=1; go to PEND; pc held.
  - !redir & imem_ready & !stall: pc<=pc_plus4.
  - Otherwise pc holds.
- PEND, per cycle:
  - exc: pend_target<=EXC_VECTOR. branch_taken and jump are ignored (wrong path).
  - imem_ready: pc<=pend_target, or EXC_VECTOR if exc arrives in the same cycle; flush=1 next cycle; pending<=0; go to RUN.
  - stall has no effect in PEND.
- fetch_valid = (state==RUN) & imem_ready & !stall & !redir. It is always 0 in BOOT and PEND.
- flush: exactly a one-cycle pulse, asserted in the cycle after pc takes a redirect target. Back-to-back redirects give back-to-back pulses.
- Wrap-around: pc=32'hFFFF_FFFC advancing gives 32'h0000_0000. No overflow flag.
- Latency:
  - Redirect to new pc: 1 clock when imem_ready=1.
  - Redirect held in PEND: N+1 clocks for N not-ready cycles.

Optional Feature:
Macro PC_SEQ_PERF_EN.
- Defined: adds two output ports, stall_cycles[31:0] and redirect_count[31:0].
  - stall_cycles increments each RUN cycle with stall=1 and no redirect.
  - redirect_count increments on each applied redirect (each flush pulse).
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Not defined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset release, imem_ready=1 held, no stall: pc sequence 0x0 (BOOT), 0x0, 0x4, 0x8, 0xC; fetch_valid low in BOOT, then high.
2. stall=1 for 3 cycles at pc=0x10: pc stays 0x10, fetch_valid=0; after release pc=0x14 next cycle.
3. branch_taken with branch_target=0x203 and stall=1 at pc=0x20: next pc=0x200; flush=1 for one cycle; fetch_valid=0 in the request cycle.
4. jump with jump_target=0x400 while imem_ready=0 for 2 cycles: pending=1, pc held; then imem_ready=1 gives pc=0x400, flush pulse, pending=0.
5. In PEND with target 0x400, exc pulse, then imem_ready: pc=0x80. A branch_taken during PEND is ignored.
6. Starting at pc=0xFFFF_FFF8, advance twice: pc goes 0xFFFF_FFFC then 0x0. Assert rst while in PEND: pc=0x0, pending=0 immediately; with PC_SEQ_PERF_EN, both counters read 0.
